// File: rtl/str_to_binary_if.sv
// Character-stream in / parsed-result out bundle for the decimal string parser.
// The slave side is the parser; the master side produces characters and consumes results.
interface str_to_binary_if #(
    parameter int WIDTH = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_err;
    logic             out_ovf;
    logic [2:0]       out_ndigits;

    modport slave (
        input  in_valid, in_char, in_last, out_ready,
        output in_ready, out_valid, out_value, out_err, out_ovf, out_ndigits
    );

    modport master (
        output in_valid, in_char, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_err, out_ovf, out_ndigits
    );
endinterface

// File: rtl/str_to_binary.sv
// Parses an ASCII decimal string (MSD first, one char per beat) into an unsigned
// WIDTH-bit value, flagging non-digits, empty strings and overflow.
module str_to_binary #(
    parameter int WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    str_to_binary_if.slave       bus
);
    localparam int               AW   = WIDTH + 4;
    localparam logic [WIDTH-1:0] MAXV = '1;

    typedef enum logic {ACC, HOLD} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [2:0]       r_ndig;
    logic             r_err;
    logic             r_ovf;

    logic             w_accept;
    logic             w_done;
    logic             w_is_digit;
    logic [AW-1:0]    w_prod;
    logic [WIDTH-1:0] w_acc_upd;
    logic [2:0]       w_ndig_upd;
    logic             w_err_upd;
    logic             w_ovf_upd;

    function automatic logic [WIDTH-1:0] sat_acc(input logic [AW-1:0] v);
        if (v > {4'b0000, MAXV}) return MAXV;
        return v[WIDTH-1:0];
    endfunction

    function automatic logic [2:0] sat_ndig(input logic [2:0] n);
        return (n == 3'd7) ? 3'd7 : n + 3'd1;
    endfunction

    assign w_accept   = bus.in_valid && (r_state == ACC);
    assign w_done     = bus.out_ready && (r_state == HOLD);
    assign w_is_digit = (bus.in_char >= 8'h30) && (bus.in_char <= 8'h39);
    // For '0'..'9' the low nibble of the ASCII code is the digit value.
    assign w_prod     = {4'b0000, r_acc} * AW'(10) + {{(AW-4){1'b0}}, bus.in_char[3:0]};

    always_comb begin
        w_acc_upd  = r_acc;
        w_ndig_upd = r_ndig;
        w_err_upd  = r_err;
        w_ovf_upd  = r_ovf;
        if (w_is_digit) begin
            w_acc_upd  = sat_acc(w_prod);
            w_ndig_upd = sat_ndig(r_ndig);
            w_ovf_upd  = r_ovf || (w_prod > {4'b0000, MAXV});
        end else begin
            w_err_upd  = 1'b1;
        end
        // A string that ends without any digit is an error even if all chars were legal.
        if (bus.in_last && (w_ndig_upd == 3'd0)) w_err_upd = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_accept && bus.in_last) w_state_nxt = HOLD;
            HOLD:    if (w_done)                  w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_ndig  <= '0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_acc  <= w_acc_upd;
                r_ndig <= w_ndig_upd;
                r_err  <= w_err_upd;
                r_ovf  <= w_ovf_upd;
            end else if (w_done) begin
                r_acc  <= '0;
                r_ndig <= '0;
                r_err  <= 1'b0;
                r_ovf  <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = (r_state == ACC);
    assign bus.out_valid   = (r_state == HOLD);
    assign bus.out_value   = r_acc;
    assign bus.out_err     = r_err;
    assign bus.out_ovf     = r_ovf;
    assign bus.out_ndigits = r_ndig;
endmodule

// File: tb/tb_str_to_binary.sv
// Directed bench for str_to_binary: hand-computed strings, back-pressure and reset cases.
module tb_str_to_binary;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    str_to_binary_if #(.WIDTH(14)) bus ();

    str_to_binary #(.WIDTH(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen there too.
    task automatic send(input string s, input bit with_last);
        for (int i = 0; i < s.len(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_char  = s[i];
            bus.in_last  = with_last && (i == s.len() - 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int val, input bit err,
                                 input bit ovf, input int nd);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".value"}, 32'(bus.out_value), 32'(val));
        check({tag, ".err"},   32'(bus.out_err),   32'(err));
        check({tag, ".ovf"},   32'(bus.out_ovf),   32'(ovf));
        check({tag, ".nd"},    32'(bus.out_ndigits), 32'(nd));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".rdy_after"},   32'(bus.in_ready),  32'd1);
        check({tag, ".valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_char   = "5";
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(bus.out_valid),   32'd0);
        check("rst.ready", 32'(bus.in_ready),    32'd1);
        check("rst.value", 32'(bus.out_value),   32'd0);
        check("rst.err",   32'(bus.out_err),     32'd0);
        check("rst.ovf",   32'(bus.out_ovf),     32'd0);
        check("rst.nd",    32'(bus.out_ndigits), 32'd0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;
        check("idle.valid", 32'(bus.out_valid), 32'd0);

        send("16383", 1'b1);
        expect_result("max", 16383, 1'b0, 1'b0, 5);
        send("16384", 1'b1);
        expect_result("ovf1", 16383, 1'b0, 1'b1, 5);
        send("99999", 1'b1);
        expect_result("ovf2", 16383, 1'b0, 1'b1, 5);
        send("00042", 1'b1);
        expect_result("lead0", 42, 1'b0, 1'b0, 5);
        send("0", 1'b1);
        expect_result("zero", 0, 1'b0, 1'b0, 1);
        send("1a2", 1'b1);
        expect_result("nondig", 12, 1'b1, 1'b0, 2);
        send("x", 1'b1);
        expect_result("empty", 0, 1'b1, 1'b0, 0);
        send("12345678", 1'b1);
        expect_result("ndsat", 16383, 1'b0, 1'b1, 7);
        send("2", 1'b1);
        expect_result("after_ovf", 2, 1'b0, 1'b0, 1);

        // Back-pressure: '7' is offered while the result for "5" is held.
        send("5", 1'b1);
        bus.in_valid = 1'b1;
        bus.in_char  = "7";
        bus.in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("bp.ready", 32'(bus.in_ready),  32'd0);
            check("bp.valid", 32'(bus.out_valid), 32'd1);
            check("bp.value", 32'(bus.out_value), 32'd5);
            check("bp.nd",    32'(bus.out_ndigits), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp.ready_next", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expect_result("bp7", 7, 1'b0, 1'b0, 1);

        // Reset mid-string discards the partial value.
        send("12", 1'b0);
        check("mid.valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid.rst_valid", 32'(bus.out_valid), 32'd0);
        send("3", 1'b1);
        expect_result("mid3", 3, 1'b0, 1'b0, 1);

        // Reset while holding a result drops it.
        send("9", 1'b1);
        check("hold.valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("hold.rst_valid", 32'(bus.out_valid), 32'd0);
        check("hold.rst_value", 32'(bus.out_value), 32'd0);
        check("hold.rst_ready", 32'(bus.in_ready),  32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/str_to_binary.md
STR_TO_BINARY -- requirements
Module: str_to_binary

Interface
REQ-001 Parameter WIDTH, default 14, sets the binary result width (max value 2^WIDTH-1; 16383 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_char/in_last carry a character beat this cycle.
REQ-005 in_ready  output  1  block can accept a character beat this cycle.
REQ-006 in_char  input  8  ASCII character, most significant digit first.
REQ-007 in_last  input  1  current beat is the final character of the string.
REQ-008 out_valid  output  1  result fields valid and held stable.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 out_value  output  WIDTH  parsed unsigned binary value.
REQ-011 out_err  output  1  string contained a non-digit character or no digits at all.
REQ-012 out_ovf  output  1  decimal value exceeded 2^WIDTH-1.
REQ-013 out_ndigits  output  3  count of digit characters accepted, saturating at 7.

Function
REQ-014 Two states SHALL exist: ACC (collecting characters) and HOLD (presenting result).
REQ-015 in_ready SHALL be 1 in ACC and 0 in HOLD; out_valid SHALL be 0 in ACC and 1 in HOLD.
REQ-016 A beat is accepted only when in_valid and in_ready are both 1 at a rising edge; no other cycle changes the accumulator.
REQ-017 Digit char (8'h30-8'h39): acc <= acc*10 + (in_char - 8'h30), computed at WIDTH+4 bits with no intermediate truncation; ndigits increments, saturating at 7.
REQ-018 If the digit update result exceeds 2^WIDTH-1, ovf SHALL set (sticky) and acc SHALL saturate to 2^WIDTH-1; later digits keep acc saturated.
REQ-019 Non-digit char: err SHALL set (sticky), acc and ndigits unchanged, char consumed.
REQ-020 Leading zeros are legal digits: they count toward ndigits and do not change the value.
REQ-021 The in_last beat is processed like any other beat, then the state moves ACC->HOLD; out_valid SHALL be 1 in the cycle after the accept (latency 1).
REQ-022 If ndigits is 0 when in_last is accepted, err SHALL be 1 and out_value 0.
REQ-023 In HOLD, out_value/out_err/out_ovf/out_ndigits SHALL be registered and stable until the handshake completes; in_valid is ignored.
REQ-024 out_valid and out_ready both 1 at an edge: state -> ACC, acc/ndigits/err/ovf cleared; in_ready SHALL be 1 in the next cycle.
REQ-025 Back-to-back strings: a beat offered in the cycle after the output handshake SHALL be accepted; maximum throughput is one string per (length+1) cycles.
REQ-026 out_value SHALL equal acc in HOLD; when ovf=1 it SHALL equal 2^WIDTH-1.

Reset
REQ-027 While rst_n=0 at a rising edge: state <= ACC, acc <= 0, ndigits <= 0, err <= 0, ovf <= 0.
REQ-028 Output values after reset: out_valid 0, in_ready 1, out_value 0, out_err 0, out_ovf 0, out_ndigits 0.
REQ-029 Reset in mid-string or in HOLD SHALL discard the partial or pending result; no out_valid pulse for the discarded string.
REQ-030 A beat presented in the same cycle as an active reset SHALL NOT be accepted.

Verification
REQ-031 "16383" (last on '3') -> out_valid 1 cycle after the last accept; value 16383, err 0, ovf 0, ndigits 5.
REQ-032 "16384" -> value 16383, ovf 1, err 0; "99999" -> value 16383, ovf 1.
REQ-033 "00042" -> value 42, ndigits 5, err 0; single "0" with last -> value 0, ndigits 1.
REQ-034 "1a2" -> value 12, err 1, ndigits 2; lone "x" with last -> value 0, err 1, ndigits 0.
REQ-035 Result held with out_ready=0 for 3 cycles while in_valid=1 offering '7' -> in_ready 0, outputs unchanged, '7' not consumed; on the out_ready edge the next cycle accepts '7'.
REQ-036 "12" followed by reset, then "3" with last -> value 3, ndigits 1; no out_valid for "12".
